magic_nor_executor: RTL and testbench

Sequential executor for NOR/NOT-mapped programs on a modelled MAGIC memristor row. It is the consumer of the gate-level NOR/NOT netlists our mapping flow emits. A netlist is loaded as an op list. Each op then runs in two cycles, one per MAGIC phase:

- INIT sets the output cell to logic 1 (LRS).
- EVAL conditionally resets that cell.

Results are read back from the cell array. The block sits between the program loader and the result checker in the memristor evaluation testbench.

---
 rtl/magic_nor_executor.sv | 71 +++++++
 tb/tb_magic_nor_executor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/magic_nor_executor.sv
// magic_nor_executor: runs a loaded NOR/NOT op list on a modelled MAGIC memristor row, INIT then EVAL per op
module magic_nor_executor #(
  parameter int CELLS = 32,
  parameter int AW = 5,
  parameter int NIN = 2,
  parameter int PW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [PW-1:0]     prog_addr,
  input  logic [3*AW:0]     prog_data,
  input  logic [PW:0]       n_ops,
  input  logic              start,
  input  logic [NIN-1:0]    in_vec,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, INIT, EVAL, DONE} state_t;
  state_t state, nxt;
  logic [3*AW:0] prog [2**PW];
  logic [CELLS-1:0] cells;
  logic [PW:0] pc, pc_nx, n_lat;
  logic is_not, ill, res;
  logic [AW-1:0] dst, sa, sb;
  function automatic logic oob(input logic [AW-1:0] a);
    return {1'b0, a} >= (AW+1)'(CELLS);
  endfunction
  assign {is_not, dst, sa, sb} = prog[pc[PW-1:0]];
  assign pc_nx = pc + (PW+1)'(1);
  assign ill = dst == sa || (!is_not && dst == sb) || oob(dst) || oob(sa) || oob(sb);
  // NOT ignores src_b, so it is masked out of the pull-down term
  assign res = ~(cells[sa] | (!is_not && cells[sb]));
  assign rd_data = oob(rd_addr) ? 1'b0 : cells[rd_addr];
  assign busy = state == INIT || state == EVAL;
  assign done = state == DONE;
  always_comb
    nxt = (state == IDLE) ? (start ? (n_ops == '0 ? DONE : INIT) : IDLE) :
          (state == INIT) ? (ill ? DONE : EVAL) :
          (state == EVAL) ? (pc_nx == n_lat ? DONE : INIT) : IDLE;
  always_ff @(posedge clk)
    if (!rst && prog_we && (state == IDLE || state == DONE)) prog[prog_addr] <= prog_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      n_lat <= '0;
      err <= 1'b0;
      cells <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        cells <= {{(CELLS-NIN){1'b0}}, in_vec};
        pc <= '0;
        err <= 1'b0;
        n_lat <= n_ops;
      end
      if (state == INIT) begin
        if (ill) err <= 1'b1;
        else cells[dst] <= 1'b1;
      end
      if (state == EVAL) begin
        cells[dst] <= cells[dst] & res;
        pc <= pc_nx;
      end
    end
  end
endmodule

// File: tb/tb_magic_nor_executor.sv
// tb_magic_nor_executor: directed and random programs checked against a per-op reference model
module tb_magic_nor_executor;
  logic clk = 0, rst = 1, prog_we = 0, start = 0;
  logic [3:0] prog_addr = 0;
  logic [15:0] prog_data = 0;
  logic [4:0] n_ops = 0, rd_addr = 0;
  logic [1:0] in_vec = 0;
  logic rd_data, busy, done, err;
  int checks = 0, failures = 0;
  logic [15:0] pm [16];
  logic [31:0] mc;
  logic merr;
  int mlat;

  magic_nor_executor dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .n_ops(n_ops), .start(start), .in_vec(in_vec), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input int op, input int d, input int a, input int b);
    return {op[0], d[4:0], a[4:0], b[4:0]};
  endfunction

  task automatic wr(input int s, input logic [15:0] d);
    prog_we = 1;
    prog_addr = 4'(s);
    prog_data = d;
    tick();
    prog_we = 0;
    pm[s] = d;
  endtask

  // Each op computes its final value directly; illegal ops stop the run
  function automatic void model(input int n, input logic [1:0] iv);
    logic [15:0] o;
    int d, a, b;
    mc = 0;
    mc[1:0] = iv;
    merr = 0;
    mlat = 2 * n + 1;
    for (int j = 0; j < n; j++) begin
      o = pm[j % 16];
      d = int'(o[14:10]);
      a = int'(o[9:5]);
      b = int'(o[4:0]);
      if (d == a || (!o[15] && d == b)) begin
        merr = 1;
        mlat = 2 * j + 2;
        break;
      end
      mc[d] = o[15] ? !mc[a] : !(mc[a] | mc[b]);
    end
  endfunction

  task automatic read_cells(output logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      v[i] = rd_data;
    end
  endtask

  // mode 1: program write while busy; mode 2: second start while busy
  task automatic run(input string tag, input int n, input logic [1:0] iv, input int mode);
    int lat, bc, dc;
    logic [31:0] v;
    lat = 0;
    bc = 0;
    dc = 0;
    model(n, iv);
    in_vec = iv;
    n_ops = 5'(n);
    start = 1;
    tick();
    start = 0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (dc == 1) begin
          lat = c;
          chk({tag, " err_at_done"}, 32'(err), 32'(merr));
        end
      end
      if (mode == 1) begin
        prog_we = (c == 3);
        prog_addr = 0;
        prog_data = enc(1, 2, 0, 0);
      end
      if (mode == 2) start = (c == 3);
      if (dc > 0 && c >= lat + 3) break;
      tick();
    end
    start = 0;
    prog_we = 0;
    chk({tag, " latency"}, 32'(lat), 32'(mlat));
    chk({tag, " done_count"}, 32'(dc), 32'd1);
    chk({tag, " busy_cycles"}, 32'(bc), 32'(mlat - 1));
    chk({tag, " err_sticky"}, 32'(err), 32'(merr));
    read_cells(v);
    chk({tag, " cells"}, v, mc);
  endtask

  initial begin
    logic [31:0] v;
    logic [1:0] iv;
    logic [15:0] ha [7];
    logic [1:0] ha_in [4];
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [15:0] ha [7];
    logic [1:0] ha_in [4];
    ha[0] = enc(1, 2, 1, 0);
    ha[1] = enc(0, 3, 2, 0);
    ha[2] = enc(1, 4, 0, 0);
    ha[3] = enc(0, 5, 1, 4);
    ha[4] = enc(0, 6, 5, 3);
    ha[5] = enc(1, 7, 6, 0);
    ha[6] = enc(0, 8, 2, 4);
    ha_in[0] = 2'b11;
    ha_in[1] = 2'b01;
    ha_in[2] = 2'b10;
    ha_in[3] = 2'b00;
    for (int i = 0; i < 16; i++) pm[i] = 0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset err", 32'(err), 0);
    read_cells(v);
    chk("reset cells", v, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) wr(i, 0);
    for (int i = 0; i < 7; i++) wr(i, ha[i]);
    for (int i = 0; i < 4; i++) begin
      run("half_adder", 7, ha_in[i], 0);
      rd_addr = 7;
      #1;
      chk("ha xor", 32'(rd_data), 32'(ha_in[i][0] ^ ha_in[i][1]));
      rd_addr = 8;
      #1;
      chk("ha and", 32'(rd_data), 32'(ha_in[i][0] & ha_in[i][1]));
    end
    run("zero_ops", 0, 2'b11, 0);
    wr(3, enc(0, 5, 5, 4));
    run("illegal", 7, 2'b11, 0);
    rd_addr = 5;
    #1;
    chk("illegal cell5", 32'(rd_data), 0);
    wr(3, ha[3]);
    in_vec = 2'b11;
    n_ops = 7;
    start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    read_cells(v);
    chk("midrst cells", v, 0);
    rst = 0;
    run("after_rst", 7, 2'b11, 0);
    run("busy_we", 7, 2'b01, 1);
    run("next_run", 7, 2'b10, 0);
    run("busy_start", 7, 2'b01, 2);
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < 16; s++)
        wr(s, enc(int'($urandom_range(0, 1)), int'($urandom_range(2, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31))));
      run("random", int'($urandom_range(0, 16)), 2'($urandom), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
